// File: rtl/multi_mode_reg_pkg.sv
// rtl/multi_mode_reg_pkg.sv - mode encodings shared by the register, its bit cell and the bench
package multi_mode_reg_pkg;

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_JK     = 3'b010;
    localparam logic [2:0] MODE_TOGGLE = 3'b011;
    localparam logic [2:0] MODE_SHL    = 3'b100;
    localparam logic [2:0] MODE_SHR    = 3'b101;
    localparam logic [2:0] MODE_CNT_UP = 3'b110;
    localparam logic [2:0] MODE_CNT_DN = 3'b111;

    // True for the modes handled by the per-bit cell
    function automatic logic is_bitwise_mode(input logic [2:0] mode);
        return (mode == MODE_HOLD) || (mode == MODE_LOAD) ||
               (mode == MODE_JK)   || (mode == MODE_TOGGLE);
    endfunction

endpackage

// File: rtl/mm_bit_cell.sv
// rtl/mm_bit_cell.sv - single-bit next-state logic for HOLD, LOAD, JK and TOGGLE
module mm_bit_cell
    import multi_mode_reg_pkg::*;
(
    input  logic [2:0] mode,
    input  logic       q,
    input  logic       d,
    input  logic       j,
    input  logic       k,
    output logic       nxt
);

    // Per-bit next state; modes handled at the top level simply hold here
    always_comb begin
        nxt = q;
        case (mode)
            MODE_LOAD:   nxt = d;
            MODE_JK: begin
                case ({j, k})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            MODE_TOGGLE: nxt = q ^ d;
            default:     nxt = q;
        endcase
    end

endmodule

// File: rtl/multi_mode_reg.sv
// rtl/multi_mode_reg.sv - multi-mode register: load, JK, toggle, shift and up/down count
module multi_mode_reg
    import multi_mode_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             sout,
    output logic             co
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cell_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            mm_bit_cell u_cell (
                .mode (mode),
                .q    (q[gi]),
                .d    (d[gi]),
                .j    (j[gi]),
                .k    (k[gi]),
                .nxt  (cell_nxt[gi])
            );
        end
    endgenerate

    // Complement is combinational so it never lags q
    assign q_n = ~q;

    // Register state: reset first, then enable, then mode-specific update; co is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            sout <= 1'b0;
            co   <= 1'b0;
        end else if (!en) begin
            co <= 1'b0;
        end else begin
            co <= 1'b0;
            if (is_bitwise_mode(mode)) begin
                q <= cell_nxt;
            end else begin
                case (mode)
                    MODE_SHL: begin
                        q    <= {q[WIDTH-2:0], sin};
                        sout <= q[WIDTH-1];
                    end
                    MODE_SHR: begin
                        q    <= {sin, q[WIDTH-1:1]};
                        sout <= q[0];
                    end
                    MODE_CNT_UP: begin
                        q  <= q + ONE;
                        co <= (q == ALL_ONES);
                    end
                    default: begin
                        q  <= q - ONE;
                        co <= (q == '0);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_mode_reg.sv
// tb/tb_multi_mode_reg.sv - directed self-checking bench for multi_mode_reg
module tb_multi_mode_reg;
    import multi_mode_reg_pkg::*;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic             sout;
    logic             co;

    int n_vec;
    int n_err;

    multi_mode_reg #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .mode (mode),
        .d    (d),
        .j    (j),
        .k    (k),
        .sin  (sin),
        .q    (q),
        .q_n  (q_n),
        .sout (sout),
        .co   (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, then sample 1 time unit after the edge
    task automatic apply(input logic e, input logic [2:0] m, input logic [7:0] dv, input logic s);
        en   = e;
        mode = m;
        d    = dv;
        sin  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(1'b1, MODE_CNT_UP, 8'h00, 1'b0);
        apply(1'b1, MODE_CNT_UP, 8'h00, 1'b0);
        n_vec++; if (q !== 8'h00)    begin n_err++; $display("FAIL reset_q: got %h want %h", q, 8'h00); end
        n_vec++; if (q_n !== 8'hFF)  begin n_err++; $display("FAIL reset_qn: got %h want %h", q_n, 8'hFF); end
        n_vec++; if (sout !== 1'b0)  begin n_err++; $display("FAIL reset_sout: got %b want 0", sout); end
        n_vec++; if (co !== 1'b0)    begin n_err++; $display("FAIL reset_co: got %b want 0", co); end
        reset = 1'b0;
    endtask

    task automatic test_jk();
        apply(1'b1, MODE_LOAD, 8'hA5, 1'b0);
        n_vec++; if (q !== 8'hA5) begin n_err++; $display("FAIL load_q: got %h want %h", q, 8'hA5); end
        j = 8'h0F; k = 8'hF0;
        apply(1'b1, MODE_JK, 8'h00, 1'b0);
        n_vec++; if (q !== 8'h0F)   begin n_err++; $display("FAIL jk_q: got %h want %h", q, 8'h0F); end
        n_vec++; if (q_n !== 8'hF0) begin n_err++; $display("FAIL jk_qn: got %h want %h", q_n, 8'hF0); end
        // all four JK combinations in one word
        apply(1'b1, MODE_LOAD, 8'hA5, 1'b0);
        j = 8'h33; k = 8'h55;
        apply(1'b1, MODE_JK, 8'hFF, 1'b1);
        n_vec++; if (q !== 8'hB2) begin n_err++; $display("FAIL jk_mix_q: got %h want %h", q, 8'hB2); end
        j = 8'h00; k = 8'h00;
    endtask

    task automatic test_count_wrap();
        logic [7:0] exp_q [3];
        logic       exp_co[3];
        exp_q  = '{8'hFF, 8'h00, 8'h01};
        exp_co = '{1'b0, 1'b1, 1'b0};
        apply(1'b1, MODE_LOAD, 8'hFE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, MODE_CNT_UP, 8'h00, 1'b0);
            n_vec++; if (q !== exp_q[i])   begin n_err++; $display("FAIL up_q[%0d]: got %h want %h", i, q, exp_q[i]); end
            n_vec++; if (co !== exp_co[i]) begin n_err++; $display("FAIL up_co[%0d]: got %b want %b", i, co, exp_co[i]); end
        end
        apply(1'b1, MODE_LOAD, 8'h01, 1'b0);
        n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL load_co: got %b want 0", co); end
        apply(1'b1, MODE_CNT_DN, 8'h00, 1'b0);
        n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL dn_q0: got %h want %h", q, 8'h00); end
        n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL dn_co0: got %b want 0", co); end
        apply(1'b1, MODE_CNT_DN, 8'h00, 1'b0);
        n_vec++; if (q !== 8'hFF) begin n_err++; $display("FAIL dn_q1: got %h want %h", q, 8'hFF); end
        n_vec++; if (co !== 1'b1) begin n_err++; $display("FAIL dn_co1: got %b want 1", co); end
    endtask

    task automatic test_shift();
        apply(1'b1, MODE_LOAD, 8'h81, 1'b0);
        apply(1'b1, MODE_SHL, 8'h00, 1'b0);
        n_vec++; if (q !== 8'h02)   begin n_err++; $display("FAIL shl_q: got %h want %h", q, 8'h02); end
        n_vec++; if (sout !== 1'b1) begin n_err++; $display("FAIL shl_sout: got %b want 1", sout); end
        apply(1'b1, MODE_HOLD, 8'hFF, 1'b0);
        n_vec++; if (q !== 8'h02)   begin n_err++; $display("FAIL hold_q: got %h want %h", q, 8'h02); end
        n_vec++; if (sout !== 1'b1) begin n_err++; $display("FAIL hold_sout: got %b want 1", sout); end
        apply(1'b1, MODE_SHR, 8'h00, 1'b1);
        n_vec++; if (q !== 8'h81)   begin n_err++; $display("FAIL shr_q: got %h want %h", q, 8'h81); end
        n_vec++; if (sout !== 1'b0) begin n_err++; $display("FAIL shr_sout: got %b want 0", sout); end
    endtask

    task automatic test_enable_hold();
        apply(1'b1, MODE_LOAD, 8'h0F, 1'b0);
        apply(1'b1, MODE_CNT_UP, 8'h00, 1'b0);
        n_vec++; if (q !== 8'h10) begin n_err++; $display("FAIL en_pre_q: got %h want %h", q, 8'h10); end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, MODE_CNT_UP, 8'h00, 1'b1);
            n_vec++; if (q !== 8'h10) begin n_err++; $display("FAIL en_hold_q[%0d]: got %h want %h", i, q, 8'h10); end
            n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL en_hold_co[%0d]: got %b want 0", i, co); end
        end
        apply(1'b1, MODE_CNT_UP, 8'h00, 1'b0);
        n_vec++; if (q !== 8'h11) begin n_err++; $display("FAIL en_resume_q: got %h want %h", q, 8'h11); end
        // co pulse is cleared when en drops right after a wrap
        apply(1'b1, MODE_LOAD, 8'hFF, 1'b0);
        apply(1'b1, MODE_CNT_UP, 8'h00, 1'b0);
        n_vec++; if (co !== 1'b1) begin n_err++; $display("FAIL en_wrap_co: got %b want 1", co); end
        apply(1'b0, MODE_CNT_UP, 8'h00, 1'b0);
        n_vec++; if (co !== 1'b0) begin n_err++; $display("FAIL en_clr_co: got %b want 0", co); end
        n_vec++; if (q !== 8'h00) begin n_err++; $display("FAIL en_clr_q: got %h want %h", q, 8'h00); end
    endtask

    task automatic test_reset_priority();
        apply(1'b1, MODE_LOAD, 8'h80, 1'b0);
        apply(1'b1, MODE_SHL, 8'h00, 1'b1);
        n_vec++; if (sout !== 1'b1) begin n_err++; $display("FAIL rp_pre_sout: got %b want 1", sout); end
        apply(1'b1, MODE_LOAD, 8'h7F, 1'b0);
        reset = 1'b1;
        apply(1'b1, MODE_CNT_UP, 8'h00, 1'b0);
        reset = 1'b0;
        n_vec++; if (q !== 8'h00)   begin n_err++; $display("FAIL rp_q: got %h want %h", q, 8'h00); end
        n_vec++; if (co !== 1'b0)   begin n_err++; $display("FAIL rp_co: got %b want 0", co); end
        n_vec++; if (sout !== 1'b0) begin n_err++; $display("FAIL rp_sout: got %b want 0", sout); end
        apply(1'b1, MODE_CNT_UP, 8'h00, 1'b0);
        n_vec++; if (q !== 8'h01) begin n_err++; $display("FAIL rp_first_q: got %h want %h", q, 8'h01); end
    endtask

    task automatic test_toggle_back_to_back();
        apply(1'b1, MODE_LOAD, 8'h3C, 1'b0);
        apply(1'b1, MODE_TOGGLE, 8'hFF, 1'b0);
        n_vec++; if (q !== 8'hC3) begin n_err++; $display("FAIL toggle_q: got %h want %h", q, 8'hC3); end
        apply(1'b1, MODE_TOGGLE, 8'h0F, 1'b0);
        n_vec++; if (q !== 8'hCC) begin n_err++; $display("FAIL toggle_mask_q: got %h want %h", q, 8'hCC); end
        apply(1'b1, MODE_LOAD, 8'h96, 1'b0);
        n_vec++; if (q !== 8'h96) begin n_err++; $display("FAIL b2b_load_q: got %h want %h", q, 8'h96); end
        apply(1'b1, MODE_SHR, 8'hFF, 1'b0);
        n_vec++; if (q !== 8'h4B)   begin n_err++; $display("FAIL b2b_shr_q: got %h want %h", q, 8'h4B); end
        n_vec++; if (sout !== 1'b0) begin n_err++; $display("FAIL b2b_shr_sout: got %b want 0", sout); end
        apply(1'b1, MODE_CNT_DN, 8'hFF, 1'b1);
        n_vec++; if (q !== 8'h4A) begin n_err++; $display("FAIL b2b_dn_q: got %h want %h", q, 8'h4A); end
    endtask

    task automatic test_ignored_inputs();
        apply(1'b1, MODE_LOAD, 8'h5A, 1'b0);
        j = 8'hFF; k = 8'hFF;
        apply(1'b1, MODE_CNT_UP, 8'hFF, 1'b1);
        n_vec++; if (q !== 8'h5B) begin n_err++; $display("FAIL ign_cnt_q: got %h want %h", q, 8'h5B); end
        apply(1'b1, MODE_HOLD, 8'hA5, 1'b1);
        n_vec++; if (q !== 8'h5B) begin n_err++; $display("FAIL ign_hold_q: got %h want %h", q, 8'h5B); end
        j = 8'h00; k = 8'h00;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        en    = 1'b0;
        mode  = MODE_HOLD;
        d     = '0;
        j     = '0;
        k     = '0;
        sin   = 1'b0;
        test_reset();
        test_jk();
        test_count_wrap();
        test_shift();
        test_enable_hold();
        test_reset_priority();
        test_toggle_back_to_back();
        test_ignored_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_mode_reg.md
MULTI_MODE_REG -- requirements
Module: multi_mode_reg

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, meaning the register width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Clock port: clk; reset port: reset.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 en  input  1  update enable; 0 = hold all state.
REQ-006 mode  input  3  operation select (see REQ-012).
REQ-007 d, j, k  input  WIDTH each  per-bit load data, JK set inputs and JK reset inputs.
REQ-008 sin  input  1  serial input for shift modes.
REQ-009 q, q_n  output  WIDTH each  register state and its bitwise complement.
REQ-010 sout  output  1  registered bit most recently shifted out.
REQ-011 co  output  1  registered one-cycle carry/borrow flag for count wrap.

Function
REQ-012 Mode encoding SHALL be: 000 HOLD, 001 LOAD, 010 JK, 011 TOGGLE, 100 SHL, 101 SHR, 110 CNT_UP, 111 CNT_DN.
REQ-013 HOLD: q unchanged.
REQ-014 LOAD: q <= d.
REQ-015 JK, per bit i: j=0,k=0 hold; j=0,k=1 clear; j=1,k=0 set; j=1,k=1 invert.
REQ-016 TOGGLE: q <= q XOR d, with d used as a per-bit toggle mask.
REQ-017 SHL: q <= {q[WIDTH-2:0], sin}; sout <= q[WIDTH-1].
REQ-018 SHR: q <= {sin, q[WIDTH-1:1]}; sout <= q[0].
REQ-019 CNT_UP: q <= q+1 modulo 2^WIDTH; CNT_DN: q <= q-1 modulo 2^WIDTH.
REQ-020 co SHALL be 1 for exactly the cycle after an edge where CNT_UP took q from all-ones to 0, or CNT_DN took q from 0 to all-ones; otherwise co SHALL be 0.
REQ-021 sout SHALL hold its value in every mode except SHL and SHR.
REQ-022 When en=0, q, sout and co SHALL hold, except that co SHALL clear to 0.
REQ-023 Every update SHALL have a latency of one edge. q_n SHALL always equal ~q, with no extra register stage.
REQ-024 The mode SHALL be sampled each edge; changing mode on consecutive cycles SHALL take effect immediately, with no idle cycle.
REQ-025 Extra bits on d, j and k SHALL be ignored in modes that do not use them.

Reset
REQ-026 On reset=1 at an edge: q=0, q_n=all-ones, sout=0, co=0.
REQ-027 reset SHALL take priority over en and mode, including mid-count and mid-shift; the in-progress operation is discarded.
REQ-028 On the first edge after reset deasserts, the block SHALL apply the current en and mode normally.

Structure
REQ-029 Mode encodings SHALL be localparams in a shared package, multi_mode_reg_pkg, reused by the testbench.
REQ-030 A single-bit sub-module, mm_bit_cell, SHALL be used:
- computes the per-bit next state for HOLD, LOAD, JK and TOGGLE;
- instantiated WIDTH times via generate.
REQ-031 Shift, count, sout and co logic SHALL live in the top level.

Verification
REQ-032 Reset and JK: reset, then LOAD d=0xA5, then JK with j=0x0F, k=0xF0 -> q=0x0F after one edge, q_n=0xF0.
REQ-033 Count wrap: LOAD 0xFE, then CNT_UP for 3 edges:
- q = 0xFF, 0x00, 0x01;
- co=1 only in the cycle q=0x00.
- Mirror case: LOAD 0x01, then CNT_DN -> q = 0x00, 0xFF; co=1 only with q=0xFF.
REQ-034 Shift: LOAD 0x81, then SHL with sin=0 -> q=0x02, sout=1. Then SHR with sin=1 -> q=0x81, sout=0.
REQ-035 Enable hold: during CNT_UP at q=0x10, drop en for 4 cycles -> q stays 0x10 and co=0; re-raise en -> q=0x11 at the next edge.
REQ-036 Reset priority: reset=1 together with en=1, mode=CNT_UP at q=0x7F -> q=0x00, co=0, sout=0 at that edge.
REQ-037 TOGGLE: q=0x3C, TOGGLE with d=0xFF -> q=0xC3. Back-to-back mode changes LOAD->SHR->CNT_DN each take effect on consecutive edges.
